pc_fetch_unit: RTL and testbench

Program-counter register and instruction-fetch sequencer of the MonoCPU. It holds the architectural PC, drives the instruction-memory request handshake, and presents the fetched instruction to decode. It consumes the next-PC mux output (PC+4 or ALU/branch target) and produces the PC+4 value that feeds that mux's sum input. Misaligned branch/jump targets redirect to a trap vector.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/pc_incrementer.sv | 9 +
 rtl/pc_fetch_unit.sv | 100 ++++++++++
 tb/tb_pc_fetch_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared MonoCPU fetch definitions: fetch FSM states, NOP encoding, default PC vectors.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0100;

endpackage

// File: rtl/pc_incrementer.sv
// Sequential-PC adder: pc + 4, wrapping modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
module pc_incrementer (
  input  logic [31:0] pc_i,
  output logic [31:0] pc_plus4_o
);

  assign pc_plus4_o = pc_i + 32'd4;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and IDLE/REQ/WAIT/DONE instruction-fetch sequencer feeding decode.
// Misaligned-target trap redirect is built only when PC_MISALIGN_TRAP_EN is defined.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
`ifdef PC_MISALIGN_TRAP_EN
  , parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        misalign_trap
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         trap_q, trap_d;

  logic [31:0]  upd_pc;
  logic         upd_trap;

`ifdef PC_MISALIGN_TRAP_EN
  assign upd_trap = |next_pc[1:0];
  assign upd_pc   = upd_trap ? TRAP_VEC : next_pc;
`else
  logic [1:0] unused_next_pc_lsbs;
  assign unused_next_pc_lsbs = next_pc[1:0];
  assign upd_trap = 1'b0;
  assign upd_pc   = {next_pc[31:2], 2'b00};
`endif

  pc_incrementer u_pc_inc (
    .pc_i       (pc_q),
    .pc_plus4_o (pc_plus4)
  );

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    trap_d         = 1'b0;
    imem_req_valid = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          state_d = DONE;
        end
      end
      DONE: begin
        // Decode consumes the word when stall drops; PC advances at the same edge.
        if (!stall) begin
          pc_d    = upd_pc;
          trap_d  = upd_trap;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      trap_q  <= trap_d;
    end
  end

  assign pc            = pc_q;
  assign imem_req_addr = pc_q;
  assign instr_valid   = (state_q == DONE);
  assign instr         = instr_valid ? instr_q : NOP_INSTR;
  assign misalign_trap = trap_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: memory responder drives handshakes, expected
// {pc, instr} pairs queued at request acceptance and checked when decode sees them.
module tb_pc_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic        misalign_trap;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_pc;

  pc_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .next_pc        (next_pc),
    .stall          (stall),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .misalign_trap  (misalign_trap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Entered and left with the DUT in REQ for model_pc.
  task automatic fetch(input int req_dly, input int rsp_dly, input logic [31:0] data,
                       input int stall_cyc, input logic [31:0] npc);
    exp_t        e;
    logic [31:0] exp_pc;
    logic        exp_trap;

    chk("req_vld", {31'd0, imem_req_valid}, 32'd1);
    chk("req_addr", imem_req_addr, model_pc);
    chk("pc_plus4", pc_plus4, model_pc + 32'd4);

    for (int i = 0; i < req_dly; i++) begin
      imem_req_ready = 1'b0;
      stall          = 1'b1;
      tick();
      chk("req_hold_vld", {31'd0, imem_req_valid}, 32'd1);
      chk("req_hold_addr", imem_req_addr, model_pc);
    end

    stall          = 1'b0;
    imem_req_ready = 1'b1;
    sb_q.push_back({model_pc, data});
    tick();
    imem_req_ready = 1'b0;
    chk("trap_one_cycle", {31'd0, misalign_trap}, 32'd0);
    chk("no_dup_req", {31'd0, imem_req_valid}, 32'd0);

    for (int i = 0; i < rsp_dly; i++) begin
      stall          = 1'b1;
      imem_rsp_valid = 1'b0;
      tick();
      chk("wait_ivld", {31'd0, instr_valid}, 32'd0);
      chk("wait_req", {31'd0, imem_req_valid}, 32'd0);
      chk("wait_instr", instr, NOP_INSTR);
    end

    stall          = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hBAD0_0000;

    chk("done_ivld", {31'd0, instr_valid}, 32'd1);
    chk("sb_depth", sb_q.size(), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("sb_pc", pc, e.pc);
      chk("sb_instr", instr, e.instr);
    end

    for (int i = 0; i < stall_cyc; i++) begin
      stall   = 1'b1;
      next_pc = 32'hDEAD_BEE1;
      tick();
      chk("stall_pc", pc, model_pc);
      chk("stall_instr", instr, data);
      chk("stall_ivld", {31'd0, instr_valid}, 32'd1);
      chk("stall_req", {31'd0, imem_req_valid}, 32'd0);
    end

`ifdef PC_MISALIGN_TRAP_EN
    exp_trap = (npc[1:0] != 2'b00);
    exp_pc   = exp_trap ? 32'h0000_0100 : npc;
`else
    exp_trap = 1'b0;
    exp_pc   = {npc[31:2], 2'b00};
`endif

    stall   = 1'b0;
    next_pc = npc;
    tick();
    model_pc = exp_pc;
    chk("upd_pc", pc, exp_pc);
    chk("upd_trap", {31'd0, misalign_trap}, {31'd0, exp_trap});
    chk("upd_ivld", {31'd0, instr_valid}, 32'd0);
    chk("upd_instr_nop", instr, NOP_INSTR);
  endtask

  initial begin
    rst            = 1'b1;
    stall          = 1'b0;
    next_pc        = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    model_pc       = 32'h0;

    tick();
    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req_vld", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_ivld", {31'd0, instr_valid}, 32'd0);
    chk("rst_trap", {31'd0, misalign_trap}, 32'd0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);

    rst = 1'b0;
    tick();
    chk("first_req_vld", {31'd0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0);

    // Straight-line, best case.
    fetch(0, 0, 32'h0050_0093, 0, model_pc + 32'd4);
    fetch(0, 0, 32'h0010_8113, 0, model_pc + 32'd4);
    chk("seq_pc8", pc, 32'h8);

    // Backpressure on both request and response.
    fetch(4, 3, 32'h0020_0193, 0, model_pc + 32'd4);

    // Stall in DONE, then jump.
    fetch(0, 0, 32'h0030_0213, 5, 32'h0000_0040);

    // Misaligned target.
    fetch(0, 1, 32'h0000_006F, 0, 32'h0000_0042);

    // Jump to top of memory and check wrap of pc_plus4.
    fetch(0, 0, 32'h0040_0293, 0, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus4, 32'h0000_0000);

    // Reset while a response is outstanding; late response must be dropped.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("mid_wait_req", {31'd0, imem_req_valid}, 32'd0);
    rst = 1'b1;
    tick();
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_ivld", {31'd0, instr_valid}, 32'd0);
    rst            = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCAFE_F00D;
    tick();
    chk("late_rsp_ivld", {31'd0, instr_valid}, 32'd0);
    chk("late_rsp_instr", instr, NOP_INSTR);
    chk("late_rsp_req", {31'd0, imem_req_valid}, 32'd1);
    tick();
    imem_rsp_valid = 1'b0;
    chk("rsp_ignored_in_req", {31'd0, instr_valid}, 32'd0);
    chk("rsp_ignored_addr", imem_req_addr, 32'h0);
    model_pc = 32'h0;

    fetch(0, 0, 32'h0050_0313, 0, model_pc + 32'd4);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
